// File: rtl/ap_com_lut_bank.sv
// Programmable bank of N_CH N_IN-input LUT compressor cells with one valid/ready output stage.
// Optional mismatch counter against exact parity is enabled by defining AP_COM_ERRCNT_EN.
module ap_com_lut_bank #(
  parameter  int N_IN = 4,
  parameter  int N_CH = 20,
  localparam int TT_W = 2 ** N_IN,
  localparam int CW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run_en,
  input  logic                 cfg_we,
  input  logic [CW-1:0]        cfg_idx,
  input  logic [TT_W-1:0]      cfg_tt,
  output logic                 cfg_ready,
  output logic                 cfg_err,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_CH*N_IN-1:0] in_bits,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N_CH-1:0]      out_y,
  output logic [15:0]          err_cnt
);

  typedef enum logic [1:0] {S_CFG, S_RUN, S_DRAIN} state_e;

  function automatic logic [TT_W-1:0] parity_tt();
    logic [TT_W-1:0] t;
    logic [N_IN-1:0] kv;
    t = '0;
    for (int k = 0; k < TT_W; k++) begin
      kv   = k[N_IN-1:0];
      t[k] = ^kv;
    end
    return t;
  endfunction

  localparam logic [TT_W-1:0] PARITY_TT = parity_tt();

  state_e                state_q, state_d;
  logic [TT_W-1:0]       tt_q [N_CH];
  logic                  out_valid_q;
  logic [N_CH-1:0]       out_y_q;
  logic                  cfg_err_q;
  logic [N_CH-1:0]       y_d;
  logic                  idx_ok, cfg_wr, cfg_bad, accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_CFG;
    else        state_q <= state_d;
  end

  // DRAIN prefers returning to RUN over finishing the handoff into CFG
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CFG:   if (run_en) state_d = S_RUN;
      S_RUN:   if (!run_en) state_d = S_DRAIN;
      S_DRAIN: begin
        if (run_en)                          state_d = S_RUN;
        else if (!out_valid_q || out_ready)  state_d = S_CFG;
      end
      default: state_d = S_CFG;
    endcase
  end

  always_comb begin
    cfg_ready = (state_q == S_CFG);
    in_ready  = (state_q == S_RUN) && (!out_valid_q || out_ready);
  end

  assign idx_ok  = ((CW+1)'(cfg_idx) < (CW+1)'(N_CH));
  assign cfg_wr  = cfg_we && cfg_ready && idx_ok;
  assign cfg_bad = cfg_we && !(cfg_ready && idx_ok);
  assign accept  = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) tt_q[i] <= PARITY_TT;
    end else begin
      for (int i = 0; i < N_CH; i++)
        if (cfg_wr && (cfg_idx == CW'(i))) tt_q[i] <= cfg_tt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cfg_err_q <= 1'b0;
    else if (cfg_bad) cfg_err_q <= 1'b1;
  end

  always_comb begin
    y_d = '0;
    for (int i = 0; i < N_CH; i++) y_d[i] = tt_q[i][in_bits[i*N_IN +: N_IN]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_y_q     <= y_d;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;
  assign cfg_err   = cfg_err_q;

`ifdef AP_COM_ERRCNT_EN
  logic [N_CH-1:0] mism;
  logic [15:0]     pop;
  logic [16:0]     sum;
  logic [15:0]     err_cnt_q, err_cnt_d;

  always_comb begin
    mism = '0;
    pop  = '0;
    for (int i = 0; i < N_CH; i++) begin
      mism[i] = y_d[i] ^ (^in_bits[i*N_IN +: N_IN]);
      pop     = pop + 16'(mism[i]);
    end
    sum       = {1'b0, err_cnt_q} + {1'b0, pop};
    err_cnt_d = err_cnt_q;
    if (state_q == S_CFG && state_d == S_RUN) err_cnt_d = '0;
    else if (accept) err_cnt_d = sum[16] ? 16'hFFFF : sum[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_ap_com_lut_bank.sv
// Directed bench for ap_com_lut_bank with a behavioural model and output scoreboard.
module tb_ap_com_lut_bank;
  localparam int N_IN = 4;
  localparam int N_CH = 20;
  localparam int CW   = 5;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 run_en, cfg_we, in_valid, out_ready;
  logic [CW-1:0]        cfg_idx;
  logic [15:0]          cfg_tt;
  logic                 cfg_ready, cfg_err, in_ready, out_valid;
  logic [N_CH*N_IN-1:0] in_bits;
  logic [N_CH-1:0]      out_y;
  logic [15:0]          err_cnt;

  ap_com_lut_bank #(.N_IN(N_IN), .N_CH(N_CH)) dut (
    .clk(clk), .rst_n(rst_n), .run_en(run_en), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_tt(cfg_tt), .cfg_ready(cfg_ready), .cfg_err(cfg_err), .in_valid(in_valid),
    .in_ready(in_ready), .in_bits(in_bits), .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int              checks = 0;
  int              errors = 0;
  logic [15:0]     mtt [N_CH];
  int              mstate;
  logic            mvalid, mcfg_err;
  int              merr;
  logic [N_CH-1:0] sb [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [N_CH-1:0] lut(input logic [N_CH*N_IN-1:0] b);
    logic [N_CH-1:0] r;
    logic [N_IN-1:0] n;
    r = '0;
    for (int i = 0; i < N_CH; i++) begin
      n    = b[i*N_IN +: N_IN];
      r[i] = mtt[i][n];
    end
    return r;
  endfunction

  function automatic int miscount(input logic [N_CH*N_IN-1:0] b);
    logic [N_CH-1:0] r;
    logic [N_IN-1:0] n;
    int c;
    r = lut(b);
    c = 0;
    for (int i = 0; i < N_CH; i++) begin
      n = b[i*N_IN +: N_IN];
      if (r[i] != ^n) c++;
    end
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) mtt[i] = 16'h6996;
    mstate = 0; mvalid = 1'b0; mcfg_err = 1'b0; merr = 0;
    sb.delete();
  endtask

  // One clock: entered just after a negedge with inputs set; checks, then advances model
  task automatic tick();
    logic exp_ir, acc, old_valid;
    #1;
    exp_ir = (mstate == 1) && (!mvalid || out_ready);
    chk("in_ready", in_ready, exp_ir);
    chk("cfg_ready", cfg_ready, mstate == 0);
    chk("out_valid", out_valid, mvalid);
    chk("cfg_err", cfg_err, mcfg_err);
    `ifdef AP_COM_ERRCNT_EN
    chk("err_cnt", err_cnt, merr);
    `else
    chk("err_cnt", err_cnt, 0);
    `endif
    old_valid = mvalid;
    if (mvalid) begin
      chk("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        chk("out_y", out_y, sb[0]);
        if (out_ready) void'(sb.pop_front());
      end
    end
    acc = in_valid && exp_ir;
    if (cfg_we) begin
      if (mstate == 0 && cfg_idx < N_CH) mtt[cfg_idx] = cfg_tt;
      else mcfg_err = 1'b1;
    end
    if (acc) begin
      sb.push_back(lut(in_bits));
      merr = merr + miscount(in_bits);
      if (merr > 16'hFFFF) merr = 16'hFFFF;
    end
    if (acc) mvalid = 1'b1;
    else if (out_ready) mvalid = 1'b0;
    case (mstate)
      0: if (run_en) begin mstate = 1; merr = 0; end
      1: if (!run_en) mstate = 2;
      default: if (run_en) mstate = 1; else if (!old_valid || out_ready) mstate = 0;
    endcase
    @(negedge clk);
  endtask

  task automatic fill(input logic [N_IN-1:0] n);
    for (int i = 0; i < N_CH; i++) in_bits[i*N_IN +: N_IN] = n;
  endtask

  initial begin
    rst_n = 1'b0; run_en = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_tt = '0;
    in_valid = 1'b0; out_ready = 1'b0; in_bits = '0;
    model_reset();
    @(negedge clk); @(negedge clk);
    chk("rst_out_y", out_y, 0);
    rst_n = 1'b1;
    tick();

    // T1: parity default
    run_en = 1'b1; tick();
    in_bits = '0; in_bits[3:0] = 4'b0111; in_valid = 1'b1; tick();
    in_valid = 1'b0; out_ready = 1'b1;
    #1 chk("t1_out_y", out_y, 20'h1); #1;
    tick();

    // T2: constant tables in cells 0 and 1
    run_en = 1'b0; tick(); tick();
    cfg_we = 1'b1; cfg_idx = 5'd0; cfg_tt = 16'h0000; tick();
    cfg_idx = 5'd1; cfg_tt = 16'hFFFF; tick();
    cfg_we = 1'b0; run_en = 1'b1; tick();
    fill(4'b0101); in_valid = 1'b1; tick();
    in_valid = 1'b0;
    #1 chk("t2_out_y", out_y, 20'h2); #1;
    tick();

    // T3: illegal index and write outside CFG
    cfg_we = 1'b1; cfg_idx = 5'd3; cfg_tt = 16'h0000; tick();
    cfg_we = 1'b0; fill(4'b0111); in_valid = 1'b1; tick();
    in_valid = 1'b0; tick();
    run_en = 1'b0; tick(); tick();
    cfg_we = 1'b1; cfg_idx = 5'd20; cfg_tt = 16'h0000; tick();
    cfg_we = 1'b0; run_en = 1'b1; tick();

    // T4: streaming then stall
    out_ready = 1'b1; in_valid = 1'b1;
    for (int v = 0; v < 8; v++) begin
      in_bits = {$urandom, $urandom, $urandom};
      tick();
    end
    out_ready = 1'b0; in_bits = {$urandom, $urandom, $urandom};
    tick(); tick(); tick();
    out_ready = 1'b1; in_valid = 1'b0; tick(); tick();

    // T5: drain with pending output
    out_ready = 1'b0; in_valid = 1'b1; fill(4'b1011); tick();
    in_valid = 1'b0; run_en = 1'b0; tick(); tick();
    out_ready = 1'b1; tick(); tick();

    // T6: async reset mid-stream
    run_en = 1'b1; tick();
    out_ready = 1'b0; in_valid = 1'b1; fill(4'b0011); tick();
    #2 rst_n = 1'b0;
    #1 chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_cfg_ready", cfg_ready, 1);
    model_reset();
    in_valid = 1'b0; run_en = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    tick();
    run_en = 1'b1; tick();
    in_bits = '0; in_bits[3:0] = 4'b0111; in_valid = 1'b1; out_ready = 1'b1; tick();
    in_valid = 1'b0; tick();

    // Saturation: two mismatching cells per vector on top of 16'hFFFE
    run_en = 1'b0; tick(); tick();
    cfg_we = 1'b1; cfg_idx = 5'd0; cfg_tt = 16'h0000; tick();
    cfg_idx = 5'd1; tick();
    cfg_we = 1'b0; run_en = 1'b1; tick();
    `ifdef AP_COM_ERRCNT_EN
    force dut.err_cnt_q = 16'hFFFE;
    #1 release dut.err_cnt_q;
    merr = 16'hFFFE;
    `endif
    fill(4'b0001); in_valid = 1'b1; tick();
    tick();
    in_valid = 1'b0; tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
